// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and the PWM capture block.
//   pwm_state_e      capture FSM states
//   PWM_CNT_W        default width of the high/low cycle counters
//   PWM_TIMEOUT      default number of edge-free cycles before a line is flagged stuck
//   PWM_SYNC_STAGES  default synchronizer depth for asynchronous PWM inputs
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_state_e;

    localparam int unsigned PWM_CNT_W       = 8;
    localparam int unsigned PWM_TIMEOUT     = 255;
    localparam int unsigned PWM_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input, followed by a
// one-cycle delay register used for edge detection.
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset, clears all flops to 0
//   d_i     in   asynchronous input
//   s_o     out  synchronized level (STAGES cycles of latency)
//   rise_o  out  s_o is 1 and was 0 the previous cycle
//   fall_o  out  s_o is 0 and was 1 the previous cycle
module sync_edge
    import pwm_pkg::*;
#(
    parameter int unsigned STAGES = PWM_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              p_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            p_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            p_q    <= sync_q[STAGES-1];
        end
    end

    assign s_o    = sync_q[STAGES-1];
    assign rise_o = s_o & ~p_q;
    assign fall_o = ~s_o & p_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform, reporting the high time and the
// period of each complete cycle, and flags a line that has stopped toggling.
//   clkin      in   single clock, rising edge
//   reset      in   asynchronous active-high reset
//   cs         in   capture enable; 0 = idle, counters cleared, results held
//   pwmin      in   PWM input, asynchronous to clkin
//   hightime   out  high cycles of the last complete period
//   period     out  high+low cycles of the last complete period
//   valid      out  one-cycle strobe when hightime/period update
//   stuck      out  sticky; no edge seen for TIMEOUT cycles, cleared by the next publish
//   stuck_lvl  out  synchronized line level when stuck was raised
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | capture disabled, counters cleared
// SEEK  | waiting for a rising edge; any partial period is discarded
// HIGH  | counting high cycles of a period whose start was observed
// LOW   | counting low cycles; the next rise closes and publishes the period
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = PWM_CNT_W,
    parameter int unsigned TIMEOUT     = PWM_TIMEOUT,
    parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             cs,
    input  logic             pwmin,
    output logic [CNT_W-1:0] hightime,
    output logic [CNT_W:0]   period,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic s, rise, fall;

    pwm_state_e       state_q;
    logic [CNT_W-1:0] hcnt_q, lcnt_q;
    logic [CNT_W-1:0] hightime_q;
    logic [CNT_W:0]   period_q;
    logic             valid_q, stuck_q, stuck_lvl_q;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clkin),
        .rst_i  (reset),
        .d_i    (pwmin),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Edges are checked before the timeout compare so an edge arriving on the
    // same cycle the counter hits TIMEOUT is measured rather than flagged.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            hightime_q  <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!cs) begin
                state_q <= IDLE;
                hcnt_q  <= '0;
                lcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SEEK;
                        hcnt_q  <= '0;
                        lcnt_q  <= '0;
                    end
                    SEEK: begin
                        if (rise) begin
                            state_q <= HIGH;
                            hcnt_q  <= ONE;
                            lcnt_q  <= '0;
                        end else if (lcnt_q == TMO) begin
                            stuck_q     <= 1'b1;
                            stuck_lvl_q <= s;
                            hcnt_q      <= '0;
                            lcnt_q      <= '0;
                        end else begin
                            lcnt_q <= lcnt_q + ONE;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state_q <= LOW;
                            lcnt_q  <= ONE;
                        end else if (hcnt_q == TMO) begin
                            state_q     <= SEEK;
                            stuck_q     <= 1'b1;
                            stuck_lvl_q <= s;
                            hcnt_q      <= '0;
                            lcnt_q      <= '0;
                        end else begin
                            hcnt_q <= hcnt_q + ONE;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            hightime_q <= hcnt_q;
                            period_q   <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
                            valid_q    <= 1'b1;
                            stuck_q    <= 1'b0;
                            state_q    <= HIGH;
                            hcnt_q     <= ONE;
                            lcnt_q     <= '0;
                        end else if (lcnt_q == TMO) begin
                            state_q     <= SEEK;
                            stuck_q     <= 1'b1;
                            stuck_lvl_q <= s;
                            hcnt_q      <= '0;
                            lcnt_q      <= '0;
                        end else begin
                            lcnt_q <= lcnt_q + ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        hcnt_q  <= '0;
                        lcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign hightime  = hightime_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign stuck_lvl = stuck_lvl_q;

endmodule
